cable50_tx: RTL and testbench
=============================

CABLE50_TX -- requirements
Module: cable50_tx

Interface
REQ-001 SHALL have parameter SETUP_CYC, default 2: cycles data is held stable on cable before strobe rises (range 1..15).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 1023: maximum cycles to wait for any ACK edge (range 1..65535).
REQ-003 SHALL have port CLK  in  1  single system clock; all logic is on its rising edge.
REQ-004 SHALL have port RST_N  in  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port WR_DATA  in  32  word to transmit.
REQ-006 SHALL have port WR_VALID  in  1  WR_DATA valid.
REQ-007 SHALL have port WR_READY  out  1  block accepts a word when WR_VALID and WR_READY are both high.
REQ-008 SHALL have port CBL_DATA  out  32  data pins of 50-pin ribbon.
REQ-009 SHALL have port CBL_PAR  out  1  parity pin.
REQ-010 SHALL have port CBL_STB  out  1  strobe pin, active-high.
REQ-011 SHALL have port CBL_ACK  in  1  acknowledge from far-end receiver; asynchronous to CLK.
REQ-012 SHALL have port ERR  out  1  sticky timeout flag.
REQ-013 SHALL have port ERR_CLR  in  1  clears ERR and leaves ERROR state.

Function
REQ-014 SHALL synchronise CBL_ACK through two flops; the FSM uses only the synchronised value ack_s.
REQ-015 SHALL implement FSM states IDLE, SETUP, STROBE, RELEASE, ERROR.
REQ-016 IDLE: WR_READY=1; on WR_VALID, latch WR_DATA into CBL_DATA and compute parity on the same edge, then go to SETUP.
REQ-017 SETUP: hold CBL_DATA; after exactly SETUP_CYC cycles in SETUP, assert CBL_STB and go to STROBE.
REQ-018 STROBE: hold CBL_STB=1 until ack_s=1; then deassert CBL_STB and go to RELEASE.
REQ-019 RELEASE: wait for ack_s=0; then go to IDLE. CBL_DATA holds its last value until the next accept.
REQ-020 WR_READY SHALL be 1 only in IDLE; one word per full 4-phase handshake.
REQ-021 Minimum accept-to-accept spacing with zero-delay ACK SHALL be SETUP_CYC+2+2+2+1 cycles; the sync latency is counted in both ACK phases.
REQ-022 A 16-bit timeout counter SHALL clear on entry to STROBE and to RELEASE, and SHALL increment each cycle in those states.
REQ-023 When the counter reaches TIMEOUT_CYC, the FSM SHALL go to ERROR, set ERR, and force CBL_STB=0.
REQ-024 ERROR: WR_READY=0; ERR_CLR=1 returns to IDLE and clears ERR on the same edge.
REQ-025 ERR_CLR SHALL be ignored outside ERROR.
REQ-026 If ack_s is already 1 on entry to SETUP (stale ACK), the block SHALL remain in SETUP with CBL_STB=0 until ack_s=0, then apply SETUP_CYC.

Reset
REQ-027 While RST_N=0: state IDLE, CBL_DATA=0, CBL_PAR=0, CBL_STB=0, ERR=0, WR_READY=0, counters=0, sync flops=0.
REQ-028 WR_READY SHALL rise on the first CLK edge after RST_N deasserts.
REQ-029 Reset mid-handshake SHALL drop CBL_STB immediately, asynchronously.

Configuration
REQ-030 With CABLE50_TX_PARITY_EN defined, CBL_PAR SHALL be odd parity over CBL_DATA (XOR of the 32 bits, inverted), registered with the data.
REQ-031 Without CABLE50_TX_PARITY_EN, CBL_PAR SHALL be constant 0 and no parity logic SHALL be synthesised.

Structure
REQ-032 A shared package cable50_pkg SHALL hold the FSM state enum, CBL_DATA_W=32, the timeout counter width (16), and the pin map (pins 1-32 data, 33 PAR, 34 STB, 35 ACK, 36-50 GND).
REQ-033 The two-flop synchroniser SHALL be the sub-module cable50_sync2 with async active-low reset; it is the only sub-module.

Verification
REQ-034 Reset, then WR_DATA=0xDEADBEEF with a responder acking after 3 cycles -> CBL_DATA=0xDEADBEEF; CBL_STB rises exactly 2 cycles after accept; CBL_PAR=1 with the macro, 0 without.
REQ-035 Back-to-back words 0x00000001, 0xFFFFFFFF with zero-delay ACK -> accepts 9 cycles apart; parity 0 then 1 (macro on).
REQ-036 ACK never returned, TIMEOUT_CYC=10 -> ERROR 10 cycles after STB rise; ERR=1, STB=0, WR_READY=0; ERR_CLR pulse -> IDLE with ERR=0.
REQ-037 ACK stuck high after the handshake, then released after 20 cycles -> new word waits in SETUP with STB=0, and STB rises 2 cycles after ack_s falls.
REQ-038 RST_N pulsed low while in STROBE -> CBL_STB=0 immediately; all outputs at reset values; normal handshake afterwards.
REQ-039 ACK glitch shorter than 1 cycle, asynchronous to CLK -> no state change unless the glitch is captured by the synchroniser; no X on outputs.

Source files
------------

// File: rtl/cable50_pkg.sv
// Shared definitions for the 50-pin ribbon-cable transmitter: FSM states,
// widths and the connector pin assignment.
package cable50_pkg;

    localparam int CBL_DATA_W = 32;
    localparam int TMO_W      = 16;

    // Connector pin map (1-based pin numbers on the ribbon)
    localparam int PIN_DATA_LO = 1;
    localparam int PIN_DATA_HI = 32;
    localparam int PIN_PAR     = 33;
    localparam int PIN_STB     = 34;
    localparam int PIN_ACK     = 35;
    localparam int PIN_GND_LO  = 36;
    localparam int PIN_GND_HI  = 50;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        STROBE  = 3'd2,
        RELEASE = 3'd3,
        ERROR   = 3'd4
    } state_t;

endpackage

// File: rtl/cable50_sync2.sv
// Two-flop synchroniser for the asynchronous ACK pin.
module cable50_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/cable50_tx.sv
// 4-phase strobe/ack transmitter driving a 50-pin ribbon cable.
// Optional odd parity on the PAR pin when CABLE50_TX_PARITY_EN is defined.
module cable50_tx
    import cable50_pkg::*;
#(
    parameter int SETUP_CYC   = 2,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CBL_DATA_W-1:0] wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic [CBL_DATA_W-1:0] cbl_data,
    output logic                  cbl_par,
    output logic                  cbl_stb,
    input  logic                  cbl_ack,
    output logic                  err,
    input  logic                  err_clr
);

    localparam logic [TMO_W-1:0] SETUP_LAST = TMO_W'(SETUP_CYC - 1);
    localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [TMO_W-1:0] CNT_ONE    = TMO_W'(1);

    state_t           state, state_d;
    logic [TMO_W-1:0] cnt, cnt_d;
    logic             stb_d, err_d, load, ack_s, armed;

    cable50_sync2 u_ack_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (cbl_ack),
        .q     (ack_s)
    );

    // armed keeps ready low until the first edge after reset release
    assign wr_ready = armed && (state == IDLE);

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        stb_d   = cbl_stb;
        err_d   = err;
        load    = 1'b0;
        case (state)
            IDLE: begin
                if (armed && wr_valid) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                // a stale ACK from the previous word holds off the setup count
                if (ack_s) begin
                    cnt_d = '0;
                end else if (cnt == SETUP_LAST) begin
                    cnt_d   = '0;
                    stb_d   = 1'b1;
                    state_d = STROBE;
                end else begin
                    cnt_d = cnt + CNT_ONE;
                end
            end
            STROBE: begin
                if (ack_s) begin
                    cnt_d   = '0;
                    stb_d   = 1'b0;
                    state_d = RELEASE;
                end else if (cnt == TMO_LAST) begin
                    cnt_d   = cnt + CNT_ONE;
                    stb_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = ERROR;
                end else begin
                    cnt_d = cnt + CNT_ONE;
                end
            end
            RELEASE: begin
                if (!ack_s) begin
                    state_d = IDLE;
                end else if (cnt == TMO_LAST) begin
                    cnt_d   = cnt + CNT_ONE;
                    err_d   = 1'b1;
                    state_d = ERROR;
                end else begin
                    cnt_d = cnt + CNT_ONE;
                end
            end
            ERROR: begin
                stb_d = 1'b0;
                if (err_clr) begin
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                stb_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            cbl_stb  <= 1'b0;
            err      <= 1'b0;
            armed    <= 1'b0;
            cbl_data <= '0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            cbl_stb <= stb_d;
            err     <= err_d;
            armed   <= 1'b1;
            if (load) begin
                cbl_data <= wr_data;
            end
        end
    end

`ifdef CABLE50_TX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cbl_par <= 1'b0;
        end else if (load) begin
            cbl_par <= ~(^wr_data);
        end
    end
`else
    assign cbl_par = 1'b0;
`endif

endmodule

// File: tb/tb_cable50_tx.sv
// Directed bench for cable50_tx: vector table of handshakes plus
// timeout, stale-ACK, mid-handshake reset and ACK-glitch sequences.
module tb_cable50_tx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] wr_data;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] cbl_data;
    logic        cbl_par;
    logic        cbl_stb;
    logic        cbl_ack;
    logic        err;
    logic        err_clr;

`ifdef CABLE50_TX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    cable50_tx #(
        .SETUP_CYC   (2),
        .TIMEOUT_CYC (10)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_data  (wr_data),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .cbl_data (cbl_data),
        .cbl_par  (cbl_par),
        .cbl_stb  (cbl_stb),
        .cbl_ack  (cbl_ack),
        .err      (err),
        .err_clr  (err_clr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        int          ack_dly;
        bit          par;
    } vec_t;

    vec_t tbl[6];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic wait_ready(input string nm);
        int n = 0;
        while (wr_ready !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        check({nm, "_ready"}, 32'(wr_ready), 32'd1);
    endtask

    // Full handshake with a responder that raises ACK ack_dly cycles after STB
    task automatic send_word(input logic [31:0] d, input int ack_dly, input bit par,
                             input string nm, output int acc_cyc);
        int n;
        wr_data  = d;
        wr_valid = 1'b1;
        n = 0;
        while (wr_ready !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        step();
        acc_cyc  = cyc;
        wr_valid = 1'b0;
        check({nm, "_data"}, cbl_data, d);
        check({nm, "_par"}, 32'(cbl_par), 32'(PAR_EN & par));
        n = 0;
        while (cbl_stb !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check({nm, "_stb_lat"}, 32'(n), 32'd2);
        repeat (ack_dly) step();
        cbl_ack = 1'b1;
        n = 0;
        while (cbl_stb !== 1'b0 && n < 20) begin
            step();
            n++;
        end
        cbl_ack = 1'b0;
        check({nm, "_stb_drop"}, 32'(cbl_stb), 32'd0);
        wait_ready(nm);
        check({nm, "_err"}, 32'(err), 32'd0);
    endtask

    initial begin
        int acc, prev_acc, n;
        bit ok;

        tbl[0] = '{32'hDEADBEEF, 3, 1'b1};
        tbl[1] = '{32'h00000001, 0, 1'b0};
        tbl[2] = '{32'hFFFFFFFF, 0, 1'b1};
        tbl[3] = '{32'h00000000, 1, 1'b1};
        tbl[4] = '{32'h80000000, 5, 1'b0};
        tbl[5] = '{32'h0F0F0F0F, 0, 1'b1};

        rst_n    = 1'b0;
        wr_data  = '0;
        wr_valid = 1'b0;
        cbl_ack  = 1'b0;
        err_clr  = 1'b0;

        // Reset values and first-edge ready
        #12;
        check("rst_ready", 32'(wr_ready), 32'd0);
        check("rst_stb", 32'(cbl_stb), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_data", cbl_data, 32'd0);
        check("rst_par", 32'(cbl_par), 32'd0);
        step();
        rst_n = 1'b1;
        check("rel_ready_pre", 32'(wr_ready), 32'd0);
        step();
        check("rel_ready_edge", 32'(wr_ready), 32'd1);

        // Vector table; zero-delay ACK words must be 9 cycles apart
        prev_acc = 0;
        for (int i = 0; i < 6; i++) begin
            send_word(tbl[i].data, tbl[i].ack_dly, tbl[i].par, $sformatf("vec%0d", i), acc);
            if (i > 0 && tbl[i-1].ack_dly == 0)
                check($sformatf("vec%0d_spacing", i), 32'(acc - prev_acc), 32'd9);
            prev_acc = acc;
        end

        // Timeout: no ACK; ERR_CLR during STROBE must be ignored
        wr_data  = 32'h13572468;
        wr_valid = 1'b1;
        step();
        wr_valid = 1'b0;
        n = 0;
        while (cbl_stb !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check("tmo_stb_lat", 32'(n), 32'd2);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("tmo_clr_ignored_stb", 32'(cbl_stb), 32'd1);
        check("tmo_clr_ignored_err", 32'(err), 32'd0);
        n = 1;
        while (err !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        check("tmo_latency", 32'(n), 32'd10);
        check("tmo_err", 32'(err), 32'd1);
        check("tmo_stb", 32'(cbl_stb), 32'd0);
        check("tmo_ready", 32'(wr_ready), 32'd0);
        repeat (3) step();
        check("tmo_err_sticky", 32'(err), 32'd1);
        check("tmo_ready_held", 32'(wr_ready), 32'd0);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("tmo_clr_err", 32'(err), 32'd0);
        check("tmo_clr_ready", 32'(wr_ready), 32'd1);

        // Stale ACK: word waits in SETUP until ACK drops
        cbl_ack = 1'b1;
        repeat (3) step();
        wr_data  = 32'h00000003;
        wr_valid = 1'b1;
        step();
        wr_valid = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (cbl_stb !== 1'b0 || wr_ready !== 1'b0 || err !== 1'b0) ok = 1'b0;
            step();
        end
        check("stale_hold", 32'(ok), 32'd1);
        check("stale_data", cbl_data, 32'h00000003);
        cbl_ack = 1'b0;
        repeat (3) step();
        check("stale_stb_early", 32'(cbl_stb), 32'd0);
        step();
        check("stale_stb_rise", 32'(cbl_stb), 32'd1);
        cbl_ack = 1'b1;
        n = 0;
        while (cbl_stb !== 1'b0 && n < 20) begin
            step();
            n++;
        end
        cbl_ack = 1'b0;
        wait_ready("stale");

        // Reset mid-handshake drops STB without a clock edge
        wr_data  = 32'hA5A5A5A5;
        wr_valid = 1'b1;
        step();
        wr_valid = 1'b0;
        repeat (2) step();
        check("mid_stb_up", 32'(cbl_stb), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_stb", 32'(cbl_stb), 32'd0);
        check("mid_rst_data", cbl_data, 32'd0);
        check("mid_rst_par", 32'(cbl_par), 32'd0);
        check("mid_rst_ready", 32'(wr_ready), 32'd0);
        check("mid_rst_err", 32'(err), 32'd0);
        step();
        rst_n = 1'b1;
        check("mid_rel_ready_pre", 32'(wr_ready), 32'd0);
        step();
        check("mid_rel_ready", 32'(wr_ready), 32'd1);
        send_word(32'h12345678, 2, 1'b0, "post_rst", acc);

        // Sub-cycle ACK glitch well away from the clock edge
        @(posedge clk);
        #3 cbl_ack = 1'b1;
        #2 cbl_ack = 1'b0;
        repeat (4) step();
        check("glitch_ready", 32'(wr_ready), 32'd1);
        check("glitch_stb", 32'(cbl_stb), 32'd0);
        check("glitch_err", 32'(err), 32'd0);
        check("glitch_x", 32'($isunknown({cbl_data, cbl_par, cbl_stb, err, wr_ready})), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
